microcode_loader: RTL and testbench

MICROCODE_LOADER -- requirements
Module: microcode_loader

---
 rtl/microcode_loader.sv | 126 ++++++++++++
 tb/tb_microcode_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_loader.sv
// microcode_loader
//
// Assembles a byte stream (most significant byte first) into 24-bit
// microcode words and writes them to consecutive table addresses. It also
// keeps a running modulo-2**24 checksum of the words it has written.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-high reset
//   start       load request; only sampled in IDLE
//   start_addr  first table address; sampled with start
//   word_count  number of words to load (0..2**ADDR_W); sampled with start
//   abort       ends a load in progress (ignored in IDLE and DONE)
//   in_data     byte stream
//   in_valid    in_data holds a valid byte
//   in_ready    a byte is accepted this cycle when in_valid is also high
//   wr_en       table write strobe, one cycle per word
//   wr_addr     table write address
//   wr_data     table write data
//   busy        high in every state except IDLE
//   done        one-cycle pulse when a load completes (never after abort)
//   checksum    sum of the words written in the current or last load
module microcode_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [23:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    B0    = 3'd1,
    B1    = 3'd2,
    B2    = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [23:0]       word;
  logic              accept;

  // Modulo-2**24 accumulation; the carry out of bit 23 is simply dropped.
  function automatic logic [23:0] csum_add(input logic [23:0] acc,
                                           input logic [23:0] w);
    return acc + w;
  endfunction

  // in_ready is a registered decode of the state, so it is safe to use here.
  assign accept  = in_valid && in_ready;
  assign wr_addr = addr;
  assign wr_data = word;

  // abort is checked before accept so it wins over a byte in the same cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (word_count == '0) ? DONE : B0;
      B0:      if (abort) nxt = IDLE; else if (accept) nxt = B1;
      B1:      if (abort) nxt = IDLE; else if (accept) nxt = B2;
      B2:      if (abort) nxt = IDLE; else if (accept) nxt = WRITE;
      WRITE:   if (abort) nxt = IDLE;
               else nxt = (remaining == (ADDR_W+1)'(1)) ? DONE : B0;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      checksum  <= '0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == B0) || (nxt == B1) || (nxt == B2);
      wr_en    <= (nxt == WRITE);
      busy     <= (nxt != IDLE);
      done     <= (nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= word_count;
            checksum  <= '0;
          end
        end
        B0: if (!abort && accept) word[23:16] <= in_data;
        B1: if (!abort && accept) word[15:8]  <= in_data;
        B2: if (!abort && accept) word[7:0]   <= in_data;
        // The write strobe is already high this cycle, even under abort,
        // so the bookkeeping for the word always happens.
        WRITE: begin
          checksum  <= csum_add(checksum, word);
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_loader.sv
module tb_microcode_loader;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              busy;
  logic              done;
  logic [23:0]       checksum;

  microcode_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Write/done monitor, sampled on the falling edge.
  logic [7:0]  ga[$];
  logic [23:0] gd[$];
  int          done_cnt;
  int          rdy_bad;
  always @(negedge clk) begin
    if (wr_en) begin
      ga.push_back(wr_addr);
      gd.push_back(wr_data);
    end
    if (done) done_cnt++;
    if (in_ready && (wr_en || done)) rdy_bad++;
  end

  // Stimulus words and expected write list for the current load.
  logic [23:0] wq[$];
  logic [7:0]  ea[$];
  logic [23:0] ed[$];

  typedef struct packed {
    logic [7:0]       addr;
    logic [8:0]       cnt;
    logic [2:0][23:0] w;
    int               abort_k;
    bit               gaps;
    int               exp_n;
    logic [1:0][7:0]  exp_a;
    logic [23:0]      exp_cks;
    bit               exp_done;
  } vec_t;
  vec_t tbl[5];

  task automatic set_vec(input int i, input logic [7:0] a, input logic [8:0] c,
                         input logic [23:0] w0, input logic [23:0] w1,
                         input logic [23:0] w2, input int k, input bit g,
                         input int en, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [23:0] cks, input bit dn);
    tbl[i].addr = a; tbl[i].cnt = c;
    tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2;
    tbl[i].abort_k = k; tbl[i].gaps = g; tbl[i].exp_n = en;
    tbl[i].exp_a[0] = a0; tbl[i].exp_a[1] = a1;
    tbl[i].exp_cks = cks; tbl[i].exp_done = dn;
  endtask

  // Issue start, stream the bytes of wq (optionally with bubbles), optionally
  // abort after abort_k accepted bytes, then wait for the block to go idle.
  task automatic do_load(input logic [7:0] a, input logic [8:0] cnt,
                         input int abort_k, input bit gaps);
    int acc, cyc, nb;
    bit got;
    logic [23:0] sh;
    ga.delete(); gd.delete(); done_cnt = 0; rdy_bad = 0;
    @(negedge clk);
    start = 1'b1; start_addr = a; word_count = cnt;
    @(negedge clk);
    start = 1'b0; word_count = 9'h1AB;
    nb = 3 * int'(cnt); acc = 0; cyc = 0;
    while (acc < nb && acc != abort_k && cyc < 2000) begin
      sh = wq[acc/3] >> (8 * (2 - acc % 3));
      in_data  = sh[7:0];
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      got = in_valid && in_ready;
      @(negedge clk);
      if (got) acc++;
      cyc++;
    end
    chk("byte_stream_timeout", cyc < 2000, 1);
    in_valid = 1'b0;
    if (abort_k >= 0) begin
      abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      chk("abort_idle_next", busy, 0);
    end
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic check_load(input string tag, input logic [23:0] exp_cks,
                            input int exp_done);
    chk({tag, "_n_writes"}, ga.size(), ea.size());
    for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
      chk({tag, "_wr_addr"}, ga[i], ea[i]);
      chk({tag, "_wr_data"}, gd[i], ed[i]);
    end
    chk({tag, "_done_pulses"}, done_cnt, exp_done);
    chk({tag, "_checksum"}, checksum, exp_cks);
    chk({tag, "_ready_in_write_done"}, rdy_bad, 0);
  endtask

  task automatic run_vec(input int i);
    wq.delete(); ea.delete(); ed.delete();
    for (int j = 0; j < int'(tbl[i].cnt) && j < 3; j++) wq.push_back(tbl[i].w[j]);
    for (int j = 0; j < tbl[i].exp_n; j++) begin
      ea.push_back(tbl[i].exp_a[j]);
      ed.push_back(tbl[i].w[j]);
    end
    do_load(tbl[i].addr, tbl[i].cnt, tbl[i].abort_k, tbl[i].gaps);
    check_load($sformatf("vec%0d", i), tbl[i].exp_cks, int'(tbl[i].exp_done));
  endtask

  initial begin
    logic [7:0]  ra;
    logic [8:0]  rc;
    int          rk, ncomp;
    longint      sum;

    reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
    abort = 1'b0; in_data = '0; in_valid = 1'b0;

    //       idx addr   cnt  w0        w1        w2        k  gap n  a0     a1     cks        done
    set_vec(0, 8'h00, 9'd2, 24'hAFC053, 24'hC053AF, 24'h0,     -1, 0, 2, 8'h00, 8'h01, 24'h701402, 1);
    set_vec(1, 8'hFF, 9'd2, 24'h000001, 24'h000002, 24'h0,     -1, 0, 2, 8'hFF, 8'h00, 24'h000003, 1);
    set_vec(2, 8'h00, 9'd2, 24'hAFC053, 24'hC053AF, 24'h0,     -1, 1, 2, 8'h00, 8'h01, 24'h701402, 1);
    set_vec(3, 8'h20, 9'd3, 24'h123456, 24'hABCDEF, 24'h0F0F0F, 5, 0, 1, 8'h20, 8'h00, 24'h123456, 0);
    set_vec(4, 8'h10, 9'd1, 24'h5A5A5A, 24'h0,      24'h0,     -1, 0, 1, 8'h10, 8'h00, 24'h5A5A5A, 1);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(i);

    // Abort (in IDLE) must not disturb anything.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_checksum", checksum, 24'h123456);

    // Asynchronous reset while in B1.
    ga.delete();
    @(negedge clk); start = 1'b1; start_addr = 8'h33; word_count = 9'd2;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk); in_valid = 1'b0;
    chk("b1_in_ready_before_reset", in_ready, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_wr_addr", wr_addr, 0);
    chk("async_rst_wr_data", wr_data, 0);
    chk("async_rst_checksum", checksum, 0);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_no_writes", ga.size(), 0);

    run_vec(4);

    // word_count = 0: done the cycle after start, no write, checksum cleared;
    // a start arriving while busy (in DONE) is ignored.
    ga.delete(); done_cnt = 0;
    @(negedge clk); start = 1'b1; start_addr = 8'h05; word_count = 9'd0;
    @(negedge clk);
    chk("wc0_done", done, 1);
    chk("wc0_checksum_cleared", checksum, 0);
    word_count = 9'd4;
    @(negedge clk); start = 1'b0;
    chk("busy_start_ignored", busy, 0);
    chk("wc0_done_single", done, 0);
    repeat (3) @(negedge clk);
    chk("busy_start_still_idle", busy, 0);
    chk("wc0_no_writes", ga.size(), 0);
    chk("wc0_done_count", done_cnt, 1);

    // Randomised loads against a word-level reference model.
    for (int t = 0; t < 40; t++) begin
      rc = 9'($urandom_range(0, 4));
      ra = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'hFD, 8'hFF))
                                       : 8'($urandom_range(0, 255));
      rk = (rc != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 * rc)) : -1;
      wq.delete(); ea.delete(); ed.delete();
      for (int j = 0; j < int'(rc); j++) wq.push_back(24'($urandom));
      ncomp = (rk < 0) ? int'(rc) : rk / 3;
      sum = 0;
      for (int j = 0; j < ncomp; j++) begin
        ea.push_back(8'((int'(ra) + j) % 256));
        ed.push_back(wq[j]);
        sum += longint'(wq[j]);
      end
      do_load(ra, rc, rk, 1'($urandom_range(0, 1)));
      check_load($sformatf("rand%0d", t), 24'(sum % (64'd1 << 24)), (rk < 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
